adder_arb12: RTL
================

# adder_arb12

Two-requester arbiter and sequencer for a shared 12-bit ripple-carry adder. Each requester presents operands `a`, `b` and `cin` over a valid/ready handshake. The block grants one requester at a time, registers its operands and holds them while the combinational carry chain settles for a fixed number of cycles. It then returns the registered sum and carry-out, tagged with the requester ID, over a valid/ready response channel. It sits between the lab's operand sources and the adder datapath.

## Interface
- `SETTLE`, default 2: cycles the adder inputs are held stable before the result is captured; legal range 1–15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_a`, `req0_b`  in  12  requester 0 operands.
- `req0_cin`  in  1  requester 0 carry-in.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_cin`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_sum`  out  12  (a + b + cin) mod 4096.
- `rsp_cout`  out  1  carry out of bit 11.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- **IDLE**
  - Grant selection: if only one `reqN_valid` is high, grant that requester.
  - If both are high, grant the requester that is not `last_grant` (round-robin).
  - `reqN_ready` = IDLE && granted N. It is combinational from the valids. At most one ready is high in any cycle.
  - On `valid && ready`: register a, b, cin and the ID; set `last_grant` to N; load `cnt` = SETTLE−1; go to SETTLE.
- **SETTLE**
  - Both readies are low.
  - If `cnt` != 0, decrement `cnt`.
  - If `cnt` == 0, capture the adder output into `rsp_sum` and `rsp_cout`, then go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_id`, `rsp_sum` and `rsp_cout` stay stable until the handshake.
  - On `rsp_ready`, go to IDLE.
  - The block accepts no new request in the same cycle as the response handshake.
- The adder is a plain 12-bit ripple chain: bit i carry-in = bit i−1 carry-out, bit 0 carry-in = registered cin.
- Operand inputs are sampled only on the accepting edge. Changes after acceptance do not affect the result.
- `last_grant` resets to 1, so the first contended grant goes to requester 0.
- Reset values:
  - state = IDLE, `cnt` = 0.
  - All output registers 0: `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_cout`.
  - Both readies 0 while `rst_n` is low.
- Reset mid-operation (SETTLE or RESP): the pending operation is discarded with no response. After release the block is in IDLE with `last_grant` = 1.

## Timing
- Accept at edge E0. `rsp_valid` rises after edge E0+SETTLE. Latency = SETTLE cycles.
- The response completes on the first edge where `rsp_valid && rsp_ready`.
- The earliest next acceptance is the following edge.
- Minimum initiation interval = SETTLE + 2 cycles when `rsp_ready` is held high.
- `rsp_valid` never drops without a handshake.
- Arbitration fairness: with both requesters continuously valid, grants strictly alternate.
- Response backpressure of any length stalls the block in RESP. No request is accepted during the stall.

## Configuration
- `ADDER_ARB12_FIXED_PRIO_EN`:
  - **Defined:** fixed priority. Requester 0 always wins when both are valid, and `last_grant` has no effect on selection.
  - **Undefined (default):** round-robin as described in Operation.
- The interface and timing are identical in both builds.

## Test plan
- Single op, SETTLE=2: req0 a=0x7FF, b=0x001, cin=0 → `rsp_valid` 2 cycles after accept; `rsp_id`=0, `rsp_sum`=0x800, `rsp_cout`=0.
- Carry wrap: req1 a=0xFFF, b=0x001, cin=1 → `rsp_id`=1, `rsp_sum`=0x001, `rsp_cout`=1. Also a=0xFFF, b=0xFFF, cin=1 → `rsp_sum`=0xFFF, `rsp_cout`=1.
- Contention, `rsp_ready` tied high, both valid for 4 operations:
  - Default build → grant order 0, 1, 0, 1, accepts spaced SETTLE+2 cycles apart.
  - `ADDER_ARB12_FIXED_PRIO_EN` build → order 0, 0, 0, 0.
- Backpressure: hold `rsp_ready` low 5 cycles in RESP and change the req0 operands after accept → `rsp_*` stable, both readies 0, sum reflects the operands captured at accept.
- Reset: assert `rst_n`=0 mid-SETTLE → all outputs 0 immediately with no response emitted. After release with both requesters valid → first grant goes to requester 0.

Source files
------------

// File: rtl/adder_arb12.sv
// Two-requester arbiter and sequencer for a shared 12-bit ripple-carry adder.
// Define ADDER_ARB12_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module adder_arb12 #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [11:0] req0_a,
    input  logic [11:0] req0_b,
    input  logic        req0_cin,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [11:0] req1_a,
    input  logic [11:0] req1_b,
    input  logic        req1_cin,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [11:0] rsp_sum,
    output logic        rsp_cout
);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e      state;
    logic [3:0]  cnt;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        op_cin;
    logic        op_id;
    logic        grant1;
    logic        accept;
    logic [11:0] sum_c;
    logic [12:0] carry;

`ifdef ADDER_ARB12_FIXED_PRIO_EN
    always_comb begin
        grant1 = ~req0_valid & req1_valid;
    end
`else
    logic last_grant;

    // Contended: favour whoever did not win last time.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant1 = ~last_grant;
        end else begin
            grant1 = req1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end
`endif

    // Readies are gated by rst_n so they stay low throughout reset.
    assign req0_ready = rst_n & (state == StIdle) & req0_valid & ~grant1;
    assign req1_ready = rst_n & (state == StIdle) & req1_valid & grant1;
    assign accept     = req0_ready | req1_ready;

    always_comb begin
        carry[0] = op_cin;
        sum_c    = '0;
        for (int i = 0; i < 12; i++) begin
            sum_c[i]     = op_a[i] ^ op_b[i] ^ carry[i];
            carry[i + 1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        op_a   <= grant1 ? req1_a : req0_a;
                        op_b   <= grant1 ? req1_b : req0_b;
                        op_cin <= grant1 ? req1_cin : req0_cin;
                        op_id  <= grant1;
                        cnt    <= 4'(SETTLE - 1);
                        state  <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_sum   <= sum_c;
                        rsp_cout  <= carry[12];
                        rsp_id    <= op_id;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
